// File: rtl/sdram_arbiter.sv
// sdram_arbiter
//   Shares one 68k-style SDRAM controller port between the CPU and a video
//   burst reader, and generates the controller's periodic refresh pulse.
//   CPU cycles pass straight through while the CPU owns the port. Video bursts
//   are fetched one word per grant. When both sides want the port, ownership
//   alternates word by word.
// Ports
//   clk, reset_n                    clock, async active-low reset
//   cpu_addr/din/uds/lds/oe/we      CPU bus in
//   cpu_dout, cpu_dtack             CPU read data / acknowledge out
//   vid_req, vid_addr               burst start request / start word address
//   vid_data, vid_valid, vid_done   fetched word, word strobe, end-of-burst strobe
//   ram_addr/din/uds/lds/oe/we      to controller
//   ram_dout, ram_dtack             from controller
//   ram_refresh                     1-clk refresh request pulse
module sdram_arbiter #(
    parameter int REFRESH_DIV = 672,
    parameter int VID_BURST   = 16,
    parameter int RD_DATA_DLY = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [23:0] cpu_addr,
    input  logic [15:0] cpu_din,
    output logic [15:0] cpu_dout,
    input  logic        cpu_uds,
    input  logic        cpu_lds,
    input  logic        cpu_oe,
    input  logic        cpu_we,
    output logic        cpu_dtack,
    input  logic        vid_req,
    input  logic [23:0] vid_addr,
    output logic [15:0] vid_data,
    output logic        vid_valid,
    output logic        vid_done,
    output logic [23:0] ram_addr,
    output logic [15:0] ram_din,
    input  logic [15:0] ram_dout,
    output logic        ram_uds,
    output logic        ram_lds,
    output logic        ram_oe,
    output logic        ram_we,
    input  logic        ram_dtack,
    output logic        ram_refresh
);

    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int DW = $clog2(RD_DATA_DLY + 1) + 1;

    typedef enum logic [2:0] {S_IDLE, S_CPU, S_VID, S_DLY, S_REL} state_t;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_VID = 1'b1;

    state_t        state_q;
    logic          owner_q;
    logic          last_q;
    logic [23:0]   vaddr_q;
    logic [8:0]    rem_q;
    logic [DW-1:0] dly_q;
    logic [15:0]   vid_data_q;
    logic          vid_valid_q;
    logic          vid_done_q;
    logic [RW-1:0] ref_cnt_q, ref_cnt_d;

    logic cpu_rq, burst_act, vid_rq;

    // ------------------------------------------------------------------
    // Refresh divider, free running regardless of arbitration state
    // ------------------------------------------------------------------
    assign ram_refresh = (ref_cnt_q == RW'(REFRESH_DIV - 1));
    assign ref_cnt_d   = ram_refresh ? '0 : ref_cnt_q + RW'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ref_cnt_q <= '0;
        else          ref_cnt_q <= ref_cnt_d;
    end

    // ------------------------------------------------------------------
    // Arbitration / sequencing FSM
    // ------------------------------------------------------------------
    assign cpu_rq    = cpu_oe | cpu_we;
    assign burst_act = (rem_q != 9'd0);
    // A fresh vid_req counts as a request in the same clock it is latched.
    assign vid_rq    = burst_act | vid_req;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            owner_q     <= OWN_VID;
            last_q      <= OWN_VID;
            vaddr_q     <= '0;
            rem_q       <= '0;
            dly_q       <= '0;
            vid_data_q  <= '0;
            vid_valid_q <= 1'b0;
            vid_done_q  <= 1'b0;
        end else begin
            vid_valid_q <= 1'b0;
            // The word strobe of the final word has just been shown.
            vid_done_q  <= vid_valid_q && (rem_q == 9'd0);
            case (state_q)
                S_IDLE: begin
                    if (!ram_dtack) begin
                        if (!burst_act && vid_req) begin
                            vaddr_q <= vid_addr;
                            rem_q   <= 9'(VID_BURST);
                        end
                        // Contested grant goes to whoever did not own the last word.
                        if (cpu_rq && (!vid_rq || last_q == OWN_VID)) begin
                            state_q <= S_CPU;
                            owner_q <= OWN_CPU;
                        end else if (vid_rq) begin
                            state_q <= S_VID;
                            owner_q <= OWN_VID;
                        end
                    end
                end
                S_CPU: begin
                    if (!cpu_rq) state_q <= S_REL;
                end
                S_VID: begin
                    if (ram_dtack) begin
                        state_q <= S_DLY;
                        dly_q   <= DW'(RD_DATA_DLY);
                    end
                end
                S_DLY: begin
                    // Capture on the edge where the count reaches zero, so the
                    // data is sampled RD_DATA_DLY clocks after dtack was seen.
                    if (dly_q <= DW'(1)) begin
                        vid_data_q  <= ram_dout;
                        vid_valid_q <= 1'b1;
                        vaddr_q     <= vaddr_q + 24'd1;
                        rem_q       <= rem_q - 9'd1;
                        state_q     <= S_REL;
                    end else begin
                        dly_q <= dly_q - DW'(1);
                    end
                end
                S_REL: begin
                    if (!ram_dtack) begin
                        state_q <= S_IDLE;
                        last_q  <= owner_q;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Port muxing. Decoded from state so an async reset drops oe/we at once.
    // ------------------------------------------------------------------
    always_comb begin
        ram_addr  = '0;
        ram_din   = '0;
        ram_uds   = 1'b0;
        ram_lds   = 1'b0;
        ram_oe    = 1'b0;
        ram_we    = 1'b0;
        cpu_dtack = 1'b0;
        case (state_q)
            S_CPU: begin
                ram_addr  = cpu_addr;
                ram_din   = cpu_din;
                ram_uds   = cpu_uds;
                ram_lds   = cpu_lds;
                ram_oe    = cpu_oe;
                ram_we    = cpu_we;
                cpu_dtack = ram_dtack;
            end
            S_VID: begin
                ram_addr = vaddr_q;
                ram_uds  = 1'b1;
                ram_lds  = 1'b1;
                ram_oe   = 1'b1;
            end
            default: ;
        endcase
    end

    assign cpu_dout  = ram_dout;
    assign vid_data  = vid_data_q;
    assign vid_valid = vid_valid_q;
    assign vid_done  = vid_done_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: small SDRAM controller model plus directed tests.
module tb_sdram_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [23:0] cpu_addr, vid_addr, ram_addr;
    logic [15:0] cpu_din, cpu_dout, vid_data, ram_din;
    logic        cpu_uds, cpu_lds, cpu_oe, cpu_we, cpu_dtack;
    logic        vid_req, vid_valid, vid_done;
    logic        ram_uds, ram_lds, ram_oe, ram_we, ram_refresh;
    logic [15:0] ram_dout;
    logic        ram_dtack;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sdram_arbiter #(.REFRESH_DIV(8), .VID_BURST(4), .RD_DATA_DLY(2)) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
        .cpu_uds(cpu_uds), .cpu_lds(cpu_lds), .cpu_oe(cpu_oe), .cpu_we(cpu_we),
        .cpu_dtack(cpu_dtack),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data),
        .vid_valid(vid_valid), .vid_done(vid_done),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
        .ram_uds(ram_uds), .ram_lds(ram_lds), .ram_oe(ram_oe), .ram_we(ram_we),
        .ram_dtack(ram_dtack), .ram_refresh(ram_refresh)
    );

    function automatic logic [15:0] memval(input logic [23:0] a);
        return a[15:0] ^ 16'hA5C3 ^ {a[23:20], 12'h000};
    endfunction

    task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- controller model ----------------
    int          m_lat  = 1;
    logic        m_slow = 1'b0;
    int          m_cnt, m_pend;
    logic [15:0] m_pdata;
    logic [23:0] wr_a[$];
    logic [15:0] wr_d[$];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ram_dtack <= 1'b0;
            ram_dout  <= '0;
            m_cnt     <= 0;
            m_pend    <= 0;
            m_pdata   <= '0;
        end else begin
            if (m_pend == 1) ram_dout <= m_pdata;
            if (m_pend != 0) m_pend <= m_pend - 1;
            if (ram_oe | ram_we) begin
                if (!ram_dtack) begin
                    if (m_cnt >= m_lat) begin
                        ram_dtack <= 1'b1;
                        m_cnt     <= 0;
                        if (ram_we) begin
                            wr_a.push_back(ram_addr);
                            wr_d.push_back(ram_din);
                        end
                        if (ram_oe) begin
                            if (m_slow) begin
                                ram_dout <= 16'hDEAD;
                                m_pdata  <= memval(ram_addr);
                                m_pend   <= 2;
                            end else begin
                                ram_dout <= memval(ram_addr);
                            end
                        end
                    end else begin
                        m_cnt <= m_cnt + 1;
                    end
                end
            end else begin
                ram_dtack <= 1'b0;
                m_cnt     <= 0;
            end
        end
    end

    // ---------------- monitor ----------------
    logic [7:0]  gnt_q[$];
    logic [23:0] gaddr_q[$];
    logic [15:0] vdat_q[$];
    int          vcnt = 0;
    int          done_cnt = 0;
    logic        prev_act = 1'b0;

    always @(negedge clk) begin
        prev_act <= ram_oe | ram_we;
        if ((ram_oe | ram_we) && !prev_act) begin
            if (ram_we) gnt_q.push_back("C");
            else begin
                gnt_q.push_back("V");
                gaddr_q.push_back(ram_addr);
            end
        end
        if (vid_valid) begin
            vdat_q.push_back(vid_data);
            vcnt <= vcnt + 1;
        end
        if (vid_done) done_cnt <= done_cnt + 1;
    end

    // ---------------- helpers ----------------
    task automatic clear_logs();
        gnt_q.delete(); gaddr_q.delete(); vdat_q.delete();
        wr_a.delete(); wr_d.delete();
    endtask

    task automatic wait_gnt(input int n, input string tag);
        logic ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (gnt_q.size() >= n) begin ok = 1'b1; break; end
        end
        chk(tag, ok, 1'b1);
    endtask

    task automatic wait_done(input int n, input string tag);
        logic ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done_cnt >= n) begin ok = 1'b1; break; end
        end
        chk(tag, ok, 1'b1);
    endtask

    task automatic cpu_write(input logic [23:0] a, input logic [15:0] d);
        logic ok = 1'b0;
        cpu_addr = a; cpu_din = d; cpu_uds = 1'b1; cpu_lds = 1'b1; cpu_we = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cpu_dtack) begin ok = 1'b1; break; end
        end
        chk("wr_ack_tmo", ok, 1'b1);
        cpu_we = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1);
    end

    // ---------------- directed tests ----------------
    initial begin
        logic [47:0] ord;
        logic        ok;
        int          d0, v0;
        reset_n = 1'b0;
        cpu_addr = '0; cpu_din = '0; cpu_uds = 1'b0; cpu_lds = 1'b0;
        cpu_oe = 1'b0; cpu_we = 1'b0; vid_req = 1'b0; vid_addr = '0;
        repeat (3) @(negedge clk);

        // reset state
        chk("rst_oe",   ram_oe,      1'b0);
        chk("rst_we",   ram_we,      1'b0);
        chk("rst_addr", ram_addr,    24'h0);
        chk("rst_ref",  ram_refresh, 1'b0);
        chk("rst_vv",   vid_valid,   1'b0);
        chk("rst_vd",   vid_done,    1'b0);
        chk("rst_ack",  cpu_dtack,   1'b0);

        // 1: refresh every 8 clks, first on clk 7
        reset_n = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            chk($sformatf("refresh_k%0d", k), ram_refresh, (k % 8) == 7);
        end

        // 2: lone CPU read
        cpu_addr = 24'h000100; cpu_uds = 1'b1; cpu_lds = 1'b1; cpu_oe = 1'b1;
        @(negedge clk);
        chk("rd_addr", ram_addr,  24'h000100);
        chk("rd_oe",   ram_oe,    1'b1);
        chk("rd_we",   ram_we,    1'b0);
        chk("rd_ack0", cpu_dtack, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (cpu_dtack) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        chk("rd_ack_tmo", ok, 1'b1);
        chk("rd_ack_fwd", cpu_dtack, ram_dtack);
        chk("rd_dout",    cpu_dout,  memval(24'h000100));
        cpu_oe = 1'b0;
        @(negedge clk);
        chk("rd_rel_oe",  ram_oe,    1'b0);
        chk("rd_rel_ack", cpu_dtack, 1'b0);
        chk("rd_rel_adr", ram_addr,  24'h0);
        repeat (3) @(negedge clk);

        // 3: burst across a 20-bit boundary, data with dtack
        clear_logs();
        d0 = done_cnt;
        vid_addr = 24'h0FFFFE; vid_req = 1'b1;
        wait_gnt(1, "b3_gnt_tmo");
        vid_req = 1'b0;
        wait_done(d0 + 1, "b3_done_tmo");
        repeat (6) @(negedge clk);
        chk("b3_words", vdat_q.size(), 4);
        chk("b3_gnts",  gaddr_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            logic [23:0] ea;
            ea = 24'h0FFFFE + 24'(i);
            if (i < gaddr_q.size()) chk($sformatf("b3_addr%0d", i), gaddr_q[i], ea);
            if (i < vdat_q.size())  chk($sformatf("b3_data%0d", i), vdat_q[i], memval(ea));
        end
        chk("b3_done", done_cnt - d0, 1);

        // 4+5: CPU writes contend with a burst; data arrives 2 clks after dtack
        clear_logs();
        m_slow = 1'b1;
        d0 = done_cnt;
        vid_addr = 24'h000200; vid_req = 1'b1;
        wait_gnt(1, "b4_gnt_tmo");
        vid_req = 1'b0;
        cpu_write(24'h000300, 16'h1234);
        cpu_write(24'h000301, 16'h5678);
        wait_done(d0 + 1, "b4_done_tmo");
        repeat (6) @(negedge clk);
        ord = '0;
        foreach (gnt_q[i]) ord = {ord[39:0], gnt_q[i]};
        chk("b4_ngnt",  gnt_q.size(), 6);
        chk("b4_order", ord, "VCVCVV");
        chk("b4_words", vdat_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            logic [23:0] ea;
            ea = 24'h000200 + 24'(i);
            if (i < vdat_q.size()) chk($sformatf("b4_data%0d", i), vdat_q[i], memval(ea));
        end
        chk("b4_nwr", wr_a.size(), 2);
        if (wr_a.size() == 2) begin
            chk("b4_wa0", wr_a[0], 24'h000300);
            chk("b4_wd0", wr_d[0], 16'h1234);
            chk("b4_wa1", wr_a[1], 24'h000301);
            chk("b4_wd1", wr_d[1], 16'h5678);
        end
        chk("b4_done", done_cnt - d0, 1);

        // 6: async reset in the middle of a video read
        clear_logs();
        m_slow = 1'b0;
        vid_addr = 24'h000400; vid_req = 1'b1;
        wait_gnt(1, "b6_gnt_tmo");
        vid_req = 1'b0;
        chk("b6_oe_pre", ram_oe, 1'b1);
        v0 = vcnt;
        #2 reset_n = 1'b0;
        #1 chk("b6_oe_async", ram_oe, 1'b0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("b6_no_valid", vcnt - v0, 0);
        chk("b6_idle_oe",  ram_oe,    1'b0);
        chk("b6_idle_adr", ram_addr,  24'h0);
        chk("b6_ngnt",     gnt_q.size(), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
